// File: rtl/vlg_run_ctrl.sv
// vlg_run_ctrl: run sequencer for a controlled block.
// A start request holds the block in reset for RST_CYCLES cycles, waits
// SETTLE_CYCLES cycles with reset released, then enables the block for
// RUN_CYCLES cycles and raises a sticky done flag. All outputs are registered.
// Ports:
//   i_clk        system clock
//   i_rst        asynchronous active-high reset
//   i_start      start pulse, honoured only in IDLE or DONE
//   i_abort      abort, higher priority than i_start
//   o_dut_rst_n  active-low reset to the controlled block
//   o_run_en     run enable to the controlled block
//   o_busy       high in RST_HOLD, SETTLE and RUN
//   o_done       sticky completion flag
//   o_cycle_cnt  RUN cycles completed in the current/last run
module vlg_run_ctrl #(
   parameter int RST_CYCLES    = 100,
   parameter int SETTLE_CYCLES = 1,
   parameter int RUN_CYCLES    = 300000,
   parameter int CNT_W         = 20
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic             i_abort,
   output logic             o_dut_rst_n,
   output logic             o_run_en,
   output logic             o_busy,
   output logic             o_done,
   output logic [CNT_W-1:0] o_cycle_cnt
);

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_RST_HOLD = 3'd1;
   localparam logic [2:0] ST_SETTLE   = 3'd2;
   localparam logic [2:0] ST_RUN      = 3'd3;
   localparam logic [2:0] ST_DONE     = 3'd4;

   // One phase counter serves all timed states; size it for the longest one.
   localparam int PH_MAX = (RUN_CYCLES > RST_CYCLES) ?
                           ((RUN_CYCLES > SETTLE_CYCLES) ? RUN_CYCLES : SETTLE_CYCLES) :
                           ((RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES);
   localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

   localparam logic [PH_W-1:0] RST_LAST    = PH_W'(RST_CYCLES - 1);
   localparam logic [PH_W-1:0] SETTLE_LAST = PH_W'(SETTLE_CYCLES - 1);
   localparam logic [PH_W-1:0] RUN_LAST    = PH_W'(RUN_CYCLES - 1);

   // The cycle counter must never wrap.
   if ((RUN_CYCLES >> CNT_W) != 0) begin : g_cnt_too_narrow
      $error("vlg_run_ctrl: RUN_CYCLES does not fit in CNT_W bits");
   end

   logic [2:0]      r_state;
   logic [2:0]      w_state_nxt;
   logic [PH_W-1:0] r_phase;
   logic [CNT_W-1:0] r_cycle_cnt;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (!i_abort && i_start) w_state_nxt = ST_RST_HOLD;
         end
         ST_RST_HOLD: begin
            if (i_abort)                  w_state_nxt = ST_IDLE;
            else if (r_phase == RST_LAST) w_state_nxt = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (i_abort)                     w_state_nxt = ST_IDLE;
            else if (r_phase == SETTLE_LAST) w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (i_abort)                  w_state_nxt = ST_IDLE;
            else if (r_phase == RUN_LAST) w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            if (i_abort)      w_state_nxt = ST_IDLE;
            else if (i_start) w_state_nxt = ST_RST_HOLD;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= ST_IDLE;
         r_phase     <= '0;
         r_cycle_cnt <= '0;
         o_dut_rst_n <= 1'b0;
         o_run_en    <= 1'b0;
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
      end else begin
         r_state <= w_state_nxt;

         // Cleared on every state entry; only advances while in a timed state.
         if (w_state_nxt != r_state) begin
            r_phase <= '0;
         end else if (r_state == ST_RST_HOLD || r_state == ST_SETTLE || r_state == ST_RUN) begin
            r_phase <= r_phase + 1'b1;
         end

         // Count the RUN cycle just completed, even on abort, so a partial
         // count survives for debug.
         if (r_state == ST_RUN) begin
            r_cycle_cnt <= r_cycle_cnt + 1'b1;
         end else if (w_state_nxt == ST_RST_HOLD) begin
            r_cycle_cnt <= '0;
         end

         // Outputs decoded from the next state so they line up with it.
         o_dut_rst_n <= (w_state_nxt == ST_SETTLE) || (w_state_nxt == ST_RUN) ||
                        (w_state_nxt == ST_DONE);
         o_run_en    <= (w_state_nxt == ST_RUN);
         o_busy      <= (w_state_nxt == ST_RST_HOLD) || (w_state_nxt == ST_SETTLE) ||
                        (w_state_nxt == ST_RUN);
         o_done      <= (w_state_nxt == ST_DONE);
      end
   end

   assign o_cycle_cnt = r_cycle_cnt;

endmodule

// File: tb/tb_vlg_run_ctrl.sv
// tb_vlg_run_ctrl: directed bench for vlg_run_ctrl with RST_CYCLES=4,
// SETTLE_CYCLES=2, RUN_CYCLES=10, CNT_W=8. Edge 1 is the first edge that
// samples i_start high.
module tb_vlg_run_ctrl;

   localparam int CNT_W = 8;

   logic             i_clk;
   logic             i_rst;
   logic             i_start;
   logic             i_abort;
   logic             o_dut_rst_n;
   logic             o_run_en;
   logic             o_busy;
   logic             o_done;
   logic [CNT_W-1:0] o_cycle_cnt;

   int n_checks;
   int n_fail;

   vlg_run_ctrl #(
      .RST_CYCLES   (4),
      .SETTLE_CYCLES(2),
      .RUN_CYCLES   (10),
      .CNT_W        (CNT_W)
   ) u_dut (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_start    (i_start),
      .i_abort    (i_abort),
      .o_dut_rst_n(o_dut_rst_n),
      .o_run_en   (o_run_en),
      .o_busy     (o_busy),
      .o_done     (o_done),
      .o_cycle_cnt(o_cycle_cnt)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic check_outs(input string tag, input logic rst_n, input logic run,
                             input logic busy, input logic done, input int cnt);
      check_val({tag, ".rst_n"}, 32'(o_dut_rst_n), 32'(rst_n));
      check_val({tag, ".run_en"}, 32'(o_run_en), 32'(run));
      check_val({tag, ".busy"}, 32'(o_busy), 32'(busy));
      check_val({tag, ".done"}, 32'(o_done), 32'(done));
      check_val({tag, ".cnt"}, 32'(o_cycle_cnt), 32'(cnt));
   endtask

   // Full run from IDLE/DONE; optional stray starts in RST_HOLD and RUN.
   task automatic run_seq(input string tag, input bit stray);
      for (int e = 1; e <= 17; e++) begin
         i_start = (e == 1) || (stray && (e == 3 || e == 11));
         tick();
         i_start = 1'b0;
         check_outs($sformatf("%s.e%0d", tag, e),
                    (e >= 5), (e >= 7 && e <= 16), (e <= 16), (e == 17),
                    (e >= 8) ? e - 7 : 0);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      i_rst    = 1'b1;
      i_start  = 1'b0;
      i_abort  = 1'b0;
      repeat (3) tick();
      check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 0);
      i_rst = 1'b0;
      repeat (2) tick();
      check_outs("idle", 1'b0, 1'b0, 1'b0, 1'b0, 0);

      // Scenario 1: basic sequence.
      run_seq("s1", 1'b0);
      repeat (3) tick();
      check_outs("s1.hold", 1'b1, 1'b0, 1'b0, 1'b1, 10);

      // Scenario 5: restart from DONE.
      run_seq("s5", 1'b0);

      // Scenario 3: stray starts while busy, from DONE.
      run_seq("s3", 1'b1);

      // Abort in DONE returns to IDLE with done cleared, count held.
      i_abort = 1'b1;
      tick();
      i_abort = 1'b0;
      check_outs("done_abort", 1'b0, 1'b0, 1'b0, 1'b0, 10);

      // Scenario 2: abort during the 3rd RUN cycle.
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      repeat (8) tick();
      check_outs("s2.run3", 1'b1, 1'b1, 1'b1, 1'b0, 2);
      i_abort = 1'b1;
      tick();
      i_abort = 1'b0;
      check_outs("s2.abort", 1'b0, 1'b0, 1'b0, 1'b0, 3);
      repeat (4) tick();
      check_outs("s2.idle", 1'b0, 1'b0, 1'b0, 1'b0, 3);

      // Scenario 4: start and abort together in IDLE.
      i_start = 1'b1;
      i_abort = 1'b1;
      tick();
      i_start = 1'b0;
      i_abort = 1'b0;
      check_outs("s4.e1", 1'b0, 1'b0, 1'b0, 1'b0, 3);
      repeat (5) tick();
      check_outs("s4.e6", 1'b0, 1'b0, 1'b0, 1'b0, 3);

      // Scenario 6: async reset between edges during SETTLE.
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      repeat (4) tick();
      check_outs("s6.settle", 1'b1, 1'b0, 1'b1, 1'b0, 0);
      #2 i_rst = 1'b1;
      #1;
      check_outs("s6.async", 1'b0, 1'b0, 1'b0, 1'b0, 0);
      #1 i_rst = 1'b0;
      repeat (8) tick();
      check_outs("s6.quiet", 1'b0, 1'b0, 1'b0, 1'b0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
